conv_out_collector: RTL and testbench
=====================================

Name: conv_out_collector

Overview:
- Receiving end of the convolution result stream.
- Accepts the free-running pixel stream produced by the conv pipeline: result data plus its delay-aligned valid strobe, with no backpressure.
- Tracks each result's position in the frame and discards results whose kernel window overlapped the image border.
- Buffers kept results in a small FIFO and presents them downstream on a ready/valid interface with end-of-frame marking.

Parameters:
- DATA_W, 16, width of one convolution result
- IMG_W, 8, input image width in pixels (>= K)
- IMG_H, 8, input image height in pixels (>= K)
- K, 2, kernel size; the first K-1 columns and rows of each frame are invalid results
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- clr  in  1  synchronous soft clear: empties the FIFO, zeroes the counters, clears overflow
- in_valid  in  1  result strobe from the pipeline, one result per high cycle
- in_data  in  DATA_W  convolution result, qualified by in_valid
- m_valid  out  1  FIFO head holds a result
- m_ready  in  1  downstream accepts the head
- m_data  out  DATA_W  head result
- m_last  out  1  head is the last kept result of its frame
- frame_done  out  1  one-cycle pulse when the last input position of a frame is consumed
- overflow  out  1  sticky: a kept result was dropped because the FIFO was full

Behaviour:
- Reset: all outputs are 0, both counters are 0, and the FIFO is empty. The same holds one cycle after clr=1. clr takes priority over in_valid and m_ready in that cycle.
- Position counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on in_valid.
  - col wraps to 0 and increments row.
  - At row=IMG_H-1, col=IMG_W-1, both wrap to 0 for the next frame.
- Keep rule: a result is kept when in_valid, col>=K-1 and row>=K-1. Kept results per frame = (IMG_W-K+1)*(IMG_H-K+1).
- last flag: stored with each FIFO entry. It is 1 only for the result at row=IMG_H-1, col=IMG_W-1.
- frame_done: registered, high the cycle after the in_valid at the final position, for exactly one cycle. It is independent of FIFO state.
- FIFO push and pop:
  - Push is a kept result.
  - Pop = m_valid && m_ready.
  - Push while full is accepted if a pop occurs in the same cycle.
  - Otherwise a push while full is dropped and overflow is set. The counters still advance.
- Empty FIFO: a pop attempt is a no-op.
- Outputs: m_valid = not empty. m_data and m_last reflect the head entry and are stable while m_valid=1 and m_ready=0.
- Latency: kept result at edge t, with the FIFO empty, gives m_valid=1 and the data visible after edge t, one cycle. No combinational path from in_valid or in_data to any output.
- Simultaneous push and pop when empty: no bypass. The push is written and m_valid rises next cycle.
- Occupancy counter: width clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- Asynchronous reset mid-frame: any stored results are discarded, and the next in_valid is treated as row 0, col 0.

Decomposition:
- Package conv_pkg holds:
  - DATA_W, IMG_W, IMG_H and K defaults shared with the conv pipeline and its valid-delay stages;
  - a clog2-based counter-width helper.
- Sub-module sync_fifo, parameters W=DATA_W+1 and DEPTH:
  - ports: push, pop, din, dout, full, empty, clr;
  - same clk/rst convention.
- Counters, keep logic, frame_done and overflow stay in conv_out_collector.

Test Plan:
- Defaults, m_ready=1, 64 consecutive in_valid with in_data=index 0..63 -> exactly 49 outputs. Data are 9..15, 17..23, ..., 57..63. m_last=1 only on 63. frame_done pulses once, the cycle after index 63. overflow=0.
- m_ready=0, same frame -> entries with values 9, 10, 11, 12 are held and m_valid=1. Subsequent kept results are dropped and overflow=1. After m_ready=1 the outputs are 9, 10, 11, 12, then m_valid=0.
- FIFO full (4 entries), m_ready=1 and a kept in_valid in the same cycle -> push accepted, occupancy stays 4, overflow stays 0.
- Gapped in_valid (1 of every 3 cycles) over two back-to-back frames -> identical 49-result sequences per frame with correct m_last. frame_done pulses twice.
- Assert rst asynchronously mid-cycle after 20 inputs with 3 entries buffered -> m_valid, overflow and frame_done drop immediately. The next frame yields the full 49 results from data 9.
- clr=1 concurrent with in_valid and m_ready -> the input is ignored and the FIFO is emptied. The next input is counted as row 0, col 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the conv pipeline and its result collector.
// Defaults here must match the pipeline's valid-delay stages.
package conv_pkg;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 2;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is taken only alongside a pop.
// Pop on empty is ignored, and clr empties the queue.
module sync_fifo #(
    parameter int W     = conv_pkg::DATA_W + 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    import conv_pkg::*;

    localparam int AW = cnt_w(DEPTH);
    localparam logic [AW-1:0] P_ONE = AW'(1);
    localparam logic [AW:0]   C_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   C_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign full   = (r_cnt == C_MAX);
    assign empty  = (r_cnt == '0);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + P_ONE;
            if (w_pop)  r_rptr <= r_rptr + P_ONE;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: it is only read while the count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push && !clr) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/conv_out_collector.sv
// Collects the conv result stream, drops border results, and buffers
// the kept ones for a ready/valid consumer with end-of-frame marking.
module conv_out_collector #(
    parameter int DATA_W     = conv_pkg::DATA_W,
    parameter int IMG_W      = conv_pkg::IMG_W,
    parameter int IMG_H      = conv_pkg::IMG_H,
    parameter int K          = conv_pkg::K,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_done,
    output logic              overflow
);
    import conv_pkg::*;

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [CW-1:0] COL_END   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_END   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_frame_done;
    logic            r_overflow;
    logic            w_col_end;
    logic            w_row_end;
    logic            w_keep;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;
    logic [DATA_W:0] w_din;
    logic [DATA_W:0] w_dout;

    assign w_col_end = (r_col == COL_END);
    assign w_row_end = (r_row == ROW_END);
    assign w_keep    = in_valid && (r_col >= COL_FIRST)
                       && (r_row >= ROW_FIRST);
    assign w_pop     = m_valid && m_ready;
    assign w_drop    = w_keep && w_full && !w_pop;
    assign w_din     = {w_col_end && w_row_end, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (clr) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= in_valid && w_col_end && w_row_end;
            r_overflow   <= r_overflow || w_drop;
            if (in_valid) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + ROW_ONE;
                end else begin
                    r_col <= r_col + COL_ONE;
                end
            end
        end
    end

    sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (w_keep),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head is masked while empty so idle outputs read as zero.
    assign m_valid    = !w_empty;
    assign m_data     = w_empty ? '0 : w_dout[DATA_W-1:0];
    assign m_last     = !w_empty && w_dout[DATA_W];
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_conv_out_collector.sv
// Bench for conv_out_collector: queue-level model of frame position,
// keep rule and a 4-entry buffer, checked every cycle.
module tb_conv_out_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_last;
    logic        frame_done;
    logic        overflow;

    conv_out_collector dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit l;
    } ent_t;

    ent_t q[$];
    int   pos;
    bit   m_ovf;
    bit   m_fd;
    int   got_d[$];
    bit   got_l[$];
    int   n_fd;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_rst();
        q.delete();
        pos   = 0;
        m_ovf = 1'b0;
        m_fd  = 1'b0;
    endtask

    function automatic bit kept(int p);
        return ((p % 8) >= 1) && ((p / 8) >= 1);
    endfunction

    task automatic model_edge(bit iv, int d, bit rdy, bit c);
        bit pop;
        bit full;
        bit keep;
        ent_t e;
        if (c) begin
            model_rst();
        end else begin
            pop  = rdy && (q.size() > 0);
            full = (q.size() == 4);
            keep = iv && kept(pos);
            m_fd = iv && (pos == 63);
            if (pop) void'(q.pop_front());
            if (keep) begin
                if (!full || pop) begin
                    e.d = d;
                    e.l = (pos == 63);
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (iv) pos = (pos + 1) % 64;
        end
    endtask

    task automatic check_outs();
        chk("m_valid", m_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("m_data", m_data, q[0].d);
            chk("m_last", m_last, q[0].l);
        end
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, m_fd);
        if (frame_done) n_fd++;
    endtask

    task automatic step(bit iv, int d, bit rdy, bit c);
        @(negedge clk);
        check_outs();
        if (m_valid && rdy && !c) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end
        in_valid = iv;
        in_data  = 16'(d);
        m_ready  = rdy;
        clr      = c;
        model_edge(iv, d, rdy, c);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        m_ready  = 1'b0;
        clr      = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rst();
        got_d.delete();
        got_l.delete();
        n_fd = 0;
    endtask

    task automatic drain();
        repeat (8) step(0, 0, 1, 0);
    endtask

    task automatic feed(int gap, bit rdy);
        for (int p = 0; p < 64; p++) begin
            step(1, p, rdy, 0);
            repeat (gap) step(0, 0, rdy, 0);
        end
    endtask

    task automatic check_frames(string tag, int nf);
        int k;
        k = 0;
        chk({tag, "_cnt"}, got_d.size(), 49 * nf);
        for (int f = 0; f < nf; f++) begin
            for (int p = 0; p < 64; p++) begin
                if (kept(p)) begin
                    if (k < got_d.size()) begin
                        chk({tag, "_data"}, got_d[k], p);
                        chk({tag, "_last"}, got_l[k], p == 63);
                    end
                    k++;
                end
            end
        end
    endtask

    initial begin
        apply_reset();
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovf", overflow, 0);

        // full frame, always ready
        feed(0, 1);
        drain();
        check_frames("p1", 1);
        chk("p1_fd", n_fd, 1);
        chk("p1_ovf", overflow, 0);

        // stalled consumer: first four kept results held
        apply_reset();
        feed(0, 0);
        step(0, 0, 0, 0);
        chk("p2_ovf", overflow, 1);
        chk("p2_hold", m_valid, 1);
        got_d.delete();
        got_l.delete();
        drain();
        chk("p2_cnt", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++)
            chk("p2_data", got_d[i], 9 + i);
        chk("p2_empty", m_valid, 0);

        // push into full FIFO alongside a pop
        apply_reset();
        for (int p = 0; p < 13; p++) step(1, p, 0, 0);
        step(1, 13, 1, 0);
        step(0, 0, 0, 0);
        chk("p3_ovf", overflow, 0);
        got_d.delete();
        got_l.delete();
        drain();
        chk("p3_cnt", got_d.size(), 4);
        if (got_d.size() == 4) chk("p3_tail", got_d[3], 13);

        // gapped input over two back-to-back frames
        apply_reset();
        feed(2, 1);
        feed(2, 1);
        drain();
        check_frames("p4", 2);
        chk("p4_fd", n_fd, 2);

        // asynchronous reset mid-frame with results buffered
        apply_reset();
        for (int p = 0; p < 17; p++) step(1, p, 1, 0);
        for (int p = 17; p < 20; p++) step(1, p, 0, 0);
        @(negedge clk);
        check_outs();
        chk("p5_buf", q.size(), 3);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("p5_valid", m_valid, 0);
        chk("p5_ovf", overflow, 0);
        chk("p5_fd", frame_done, 0);
        model_rst();
        @(negedge clk);
        #1;
        rst = 1'b0;
        got_d.delete();
        got_l.delete();
        feed(0, 1);
        drain();
        check_frames("p5", 1);

        // clr beats a concurrent input and pop
        apply_reset();
        for (int p = 0; p < 11; p++) step(1, p, 0, 0);
        step(1, 999, 1, 1);
        step(0, 0, 0, 0);
        chk("p6_empty", m_valid, 0);
        got_d.delete();
        got_l.delete();
        feed(0, 1);
        drain();
        check_frames("p6", 1);

        // random traffic with occasional clr
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 65535),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 199) == 0);
        end
        drain();
        @(negedge clk);
        check_outs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
